instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Sequencer on the read side of the 8-entry, 12-bit instruction memory.
- Drives the memory read index (program counter) and captures the returned instruction.
- Presents each instruction to the downstream decode stage with a valid/ready handshake.
- Handles sequential advance, taken jumps, a halt opcode, an external halt request, and end-of-program stop or wrap.

Parameters:
- ADDR_W, 3, width of the memory index and program counter.
- INSTR_W, 12, instruction width.
- DEPTH, 8, number of memory entries (2**ADDR_W).
- STOP_AT_END, 1: 1 = halt after consuming entry DEPTH-1; 0 = wrap to 0.
- HALT_OPCODE, 4'hF, value of instr[INSTR_W-1 -: 4] that marks a halt instruction.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin or restart execution from pc 0.
- index  out  ADDR_W  read index to instruction memory; always equals pc.
- mem_instruction  in  INSTR_W  memory read data; combinational function of index.
- instr  out  INSTR_W  captured instruction presented to decode.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  decode accepts instr.
- jump  in  1  taken branch, qualified by the handshake.
- jump_target  in  ADDR_W  branch destination.
- halt_req  in  1  external stop request.
- pc  out  ADDR_W  current program counter.
- running  out  1  high in FETCH or PRESENT.
- done  out  1  high in HALTED.

Behaviour:
- Reset (async, immediate, also mid-operation): state=IDLE, pc=0, instr=0, instr_valid=0, running=0, done=0.
- All outputs are registered or decoded from state; no combinational in-to-out path.
- IDLE: hold pc=0. start -> FETCH next edge.
- FETCH: instr <= mem_instruction at index=pc. Next edge -> PRESENT with instr_valid=1. Fetch latency is 1 cycle from entering FETCH.
- PRESENT: instr and instr_valid are held stable until the handshake (instr_valid & instr_ready). On the handshake edge:
  - If instr opcode == HALT_OPCODE: -> HALTED; pc unchanged.
  - Else if jump: pc <= jump_target; -> FETCH.
  - Else if pc == DEPTH-1 and STOP_AT_END: -> HALTED; pc unchanged.
  - Else: pc <= pc+1 (mod DEPTH); -> FETCH.
  - instr_valid drops to 0 on the same edge.
- jump without a handshake is ignored; jump_target is sampled only on the handshake edge.
- halt_req in FETCH or PRESENT: -> HALTED next edge; instr_valid=0; an in-progress FETCH capture is discarded.
  - If halt_req coincides with a handshake, the handshake completes first (pc updates per the rules above), then -> HALTED.
  - halt_req in IDLE or HALTED has no effect.
- HALTED: done=1; pc and instr hold. start -> pc <= 0, -> FETCH.
- start in FETCH or PRESENT is ignored.
- Throughput: one instruction per 2 cycles at best (FETCH, PRESENT).

Decomposition:
- Shared package (cpu_pkg):
  - ADDR_W, INSTR_W, DEPTH, HALT_OPCODE constants.
  - instr_t (logic [INSTR_W-1:0]) and addr_t typedefs.
  - fetch_state_t enum {IDLE, FETCH, PRESENT, HALTED}.
- Single module; no sub-module needed. The pc next-value logic stays inline.

Test Plan:
- Memory loaded with 0..7, STOP_AT_END=1, instr_ready=1, pulse start -> instr_valid pulses at alternate cycles with instr=0,1,...,7; after the handshake on 7, done=1, pc=7, instr_valid=0.
- Same contents, instr_ready low for 5 cycles while instr=3 is presented -> instr stays 3, instr_valid stays 1, pc stays 3; release -> next instr=4.
- At pc=2, jump=1 with jump_target=6 on the handshake -> next instr=6, pc=6; jump=1 without instr_ready -> pc unchanged.
- Entry 4 = 12'hF00 -> after the handshake on 12'hF00, done=1, pc=4; the next pulse of start -> instr=0 presented again.
- STOP_AT_END=0 -> after instr 7, next instr=0 (pc wraps to 0); halt_req during PRESENT of instr 2 without a handshake -> HALTED next edge, pc=2.
- Assert reset asynchronously mid-PRESENT (between clock edges) -> instr_valid=0, pc=0, done=0, running=0 immediately; deassert and pulse start -> instr=0 fetched.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, instruction/address types and fetch sequencer states.
package cpu_pkg;
  localparam int ADDR_W = 3;
  localparam int INSTR_W = 12;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] HALT_OPCODE = 4'hF;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, HALTED} fetch_state_t;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: walks the instruction memory and hands each word to decode via valid/ready.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter bit STOP_AT_END = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  output addr_t  index,
  input  instr_t mem_instruction,
  output instr_t instr,
  output logic   instr_valid,
  input  logic   instr_ready,
  input  logic   jump,
  input  addr_t  jump_target,
  input  logic   halt_req,
  output addr_t  pc,
  output logic   running,
  output logic   done
);
  fetch_state_t state;
  logic keep;
  addr_t nxt_pc;
  // keep: the accepted instruction ends execution, so pc must not move
  assign keep = (instr[INSTR_W-1 -: 4] == HALT_OPCODE) ||
                (!jump && STOP_AT_END && pc == addr_t'(DEPTH - 1));
  assign nxt_pc = keep ? pc : jump ? jump_target : pc + addr_t'(1);
  assign index = pc;
  assign running = state == FETCH || state == PRESENT;
  assign done = state == HALTED;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      instr <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= FETCH;
        FETCH: begin
          state <= halt_req ? HALTED : PRESENT;
          instr_valid <= !halt_req;
          if (!halt_req) instr <= mem_instruction;
        end
        PRESENT: if (instr_ready || halt_req) begin
          instr_valid <= 1'b0;
          state <= (keep && instr_ready) || halt_req ? HALTED : FETCH;
          if (instr_ready) pc <= nxt_pc;
        end
        HALTED: if (start) begin
          pc <= '0;
          state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus a randomized run against a transaction-level model.
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic instr_ready = 1'b0;
  logic jump = 1'b0;
  logic [2:0] jump_target = '0;
  logic halt_req = 1'b0;
  logic [11:0] mem [8];
  logic [2:0] a_index, a_pc, b_index, b_pc;
  logic [11:0] a_mem, a_instr, b_mem, b_instr;
  logic a_valid, a_running, a_done, b_valid, b_running, b_done;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign a_mem = mem[a_index];
  assign b_mem = mem[b_index];

  instruction_fetch #(.STOP_AT_END(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .index(a_index), .mem_instruction(a_mem),
    .instr(a_instr), .instr_valid(a_valid), .instr_ready(instr_ready), .jump(jump),
    .jump_target(jump_target), .halt_req(halt_req), .pc(a_pc), .running(a_running), .done(a_done)
  );

  instruction_fetch #(.STOP_AT_END(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .index(b_index), .mem_instruction(b_mem),
    .instr(b_instr), .instr_valid(b_valid), .instr_ready(instr_ready), .jump(jump),
    .jump_target(jump_target), .halt_req(halt_req), .pc(b_pc), .running(b_running), .done(b_done)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    instr_ready = 1'b0;
    jump = 1'b0;
    halt_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8; i++) mem[i] = 12'(i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // returns number of negedges waited until valid (10 means it never came)
  task automatic wait_valid(input bit use_b, output int n);
    n = 0;
    while (!(use_b ? b_valid : a_valid) && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({a_pc, a_index, a_instr, a_valid, a_running, a_done} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_a got pc=%0d idx=%0d instr=%h v=%b r=%b d=%b exp all zero",
               a_pc, a_index, a_instr, a_valid, a_running, a_done);
    end
    n_cmp++;
    if ({b_pc, b_instr, b_valid, b_running, b_done} !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_b got pc=%0d instr=%h v=%b r=%b d=%b exp all zero",
               b_pc, b_instr, b_valid, b_running, b_done);
    end
    halt_req = 1'b1;
    repeat (3) @(negedge clk);
    halt_req = 1'b0;
    n_cmp++;
    if ({a_running, a_done, a_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_hold got r=%b d=%b v=%b exp 000", a_running, a_done, a_valid);
    end
  endtask

  task automatic test_sequential();
    int n;
    do_reset();
    load_ramp();
    instr_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      wait_valid(1'b0, n);
      n_cmp++;
      if (n != 1) begin
        n_bad++;
        $display("FAIL seq_latency k=%0d got %0d cycles exp 1", k, n);
      end
      n_cmp++;
      if (a_instr !== 12'(k) || a_pc !== 3'(k)) begin
        n_bad++;
        $display("FAIL seq_instr k=%0d got instr=%h pc=%0d exp %h/%0d", k, a_instr, a_pc, k, k);
      end
      @(negedge clk);
      n_cmp++;
      if (a_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL seq_valid_drop k=%0d got %b exp 0", k, a_valid);
      end
    end
    n_cmp++;
    if ({a_done, a_running, a_pc} !== {1'b1, 1'b0, 3'd7}) begin
      n_bad++;
      $display("FAIL seq_end got done=%b run=%b pc=%0d exp 1/0/7", a_done, a_running, a_pc);
    end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    load_ramp();
    instr_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      wait_valid(1'b0, n);
      if (k < 3) @(negedge clk);
    end
    instr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_valid, a_instr, a_pc} !== {1'b1, 12'd3, 3'd3}) begin
        n_bad++;
        $display("FAIL stall_hold c=%0d got v=%b instr=%h pc=%0d exp 1/003/3", c, a_valid, a_instr, a_pc);
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    wait_valid(1'b0, n);
    n_cmp++;
    if (n >= 10 || a_instr !== 12'd4) begin
      n_bad++;
      $display("FAIL stall_release got instr=%h wait=%0d exp 004", a_instr, n);
    end
  endtask

  task automatic test_jump();
    int n;
    do_reset();
    load_ramp();
    instr_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      wait_valid(1'b0, n);
      if (k < 2) @(negedge clk);
    end
    jump = 1'b1;
    jump_target = 3'd6;
    @(negedge clk);
    jump = 1'b0;
    jump_target = 3'd0;
    wait_valid(1'b0, n);
    n_cmp++;
    if (n >= 10 || a_instr !== 12'd6 || a_pc !== 3'd6) begin
      n_bad++;
      $display("FAIL jump_taken got instr=%h pc=%0d exp 006/6", a_instr, a_pc);
    end
    instr_ready = 1'b0;
    jump = 1'b1;
    jump_target = 3'd1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (a_pc !== 3'd6 || a_instr !== 12'd6 || a_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL jump_no_hs got pc=%0d instr=%h v=%b exp 6/006/1", a_pc, a_instr, a_valid);
    end
    jump = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    wait_valid(1'b0, n);
    n_cmp++;
    if (n >= 10 || a_instr !== 12'd7) begin
      n_bad++;
      $display("FAIL jump_after got instr=%h exp 007", a_instr);
    end
  endtask

  task automatic test_halt_opcode();
    int n;
    do_reset();
    load_ramp();
    mem[4] = 12'hF00;
    instr_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      wait_valid(1'b0, n);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({a_done, a_valid, a_pc} !== {1'b1, 1'b0, 3'd4}) begin
      n_bad++;
      $display("FAIL halt_op got done=%b v=%b pc=%0d exp 1/0/4", a_done, a_valid, a_pc);
    end
    pulse_start();
    wait_valid(1'b0, n);
    n_cmp++;
    if (n >= 10 || a_instr !== 12'd0 || a_pc !== 3'd0) begin
      n_bad++;
      $display("FAIL halt_restart got instr=%h pc=%0d exp 000/0", a_instr, a_pc);
    end
  endtask

  task automatic test_wrap_and_halt_req();
    int n;
    do_reset();
    load_ramp();
    instr_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 11; k++) begin
      wait_valid(1'b1, n);
      n_cmp++;
      if (n >= 10 || b_instr !== 12'(k % 8) || b_pc !== 3'(k % 8)) begin
        n_bad++;
        $display("FAIL wrap_seq k=%0d got instr=%h pc=%0d exp %0d", k, b_instr, b_pc, k % 8);
      end
      if (k < 10) @(negedge clk);
    end
    instr_ready = 1'b0;
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    n_cmp++;
    if ({b_done, b_valid, b_running, b_pc} !== {1'b1, 1'b0, 1'b0, 3'd2}) begin
      n_bad++;
      $display("FAIL halt_req got done=%b v=%b run=%b pc=%0d exp 1/0/0/2", b_done, b_valid, b_running, b_pc);
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    load_ramp();
    instr_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      wait_valid(1'b0, n);
      if (k < 3) @(negedge clk);
    end
    instr_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({a_valid, a_pc, a_done, a_running, a_instr} !== 18'd0) begin
      n_bad++;
      $display("FAIL async_reset got v=%b pc=%0d d=%b r=%b instr=%h exp all zero",
               a_valid, a_pc, a_done, a_running, a_instr);
    end
    @(negedge clk);
    reset = 1'b0;
    instr_ready = 1'b1;
    pulse_start();
    wait_valid(1'b0, n);
    n_cmp++;
    if (n >= 10 || a_instr !== 12'd0 || a_pc !== 3'd0) begin
      n_bad++;
      $display("FAIL async_restart got instr=%h pc=%0d exp 000/0", a_instr, a_pc);
    end
  endtask

  // model: expected observation per cycle (0 fetching, 1 presenting mem[mpc], 2 halted at mpc)
  task automatic test_random();
    int ph;
    logic [2:0] mpc;
    logic rd, hq;
    do_reset();
    for (int i = 0; i < 8; i++)
      mem[i] = ($urandom_range(0, 5) == 0) ? {4'hF, 8'($urandom)} : {4'($urandom_range(0, 14)), 8'($urandom)};
    pulse_start();
    mpc = 3'd0;
    ph = 0;
    for (int c = 0; c < 400; c++) begin
      start = 1'b0;
      jump = 1'b0;
      instr_ready = 1'b0;
      halt_req = 1'b0;
      if (ph == 0) begin
        n_cmp++;
        if ({a_valid, a_running, a_done} !== 3'b010) begin
          n_bad++;
          $display("FAIL rnd_fetch c=%0d got v/r/d=%b%b%b exp 010", c, a_valid, a_running, a_done);
        end
        hq = $urandom_range(0, 19) == 0;
        halt_req = hq;
        ph = hq ? 2 : 1;
      end else if (ph == 1) begin
        n_cmp++;
        if ({a_valid, a_running, a_done} !== 3'b110 || a_instr !== mem[mpc] || a_pc !== mpc || a_index !== mpc) begin
          n_bad++;
          $display("FAIL rnd_present c=%0d got v/r/d=%b%b%b instr=%h pc=%0d exp 110 %h pc=%0d",
                   c, a_valid, a_running, a_done, a_instr, a_pc, mem[mpc], mpc);
        end
        rd = $urandom_range(0, 2) != 0;
        hq = $urandom_range(0, 19) == 0;
        instr_ready = rd;
        halt_req = hq;
        jump = $urandom_range(0, 3) == 0;
        jump_target = 3'($urandom);
        if (rd) begin
          if (mem[mpc][11:8] == 4'hF) ph = 2;
          else if (jump) begin mpc = jump_target; ph = 0; end
          else if (mpc == 3'd7) ph = 2;
          else begin mpc = mpc + 3'd1; ph = 0; end
        end
        if (hq) ph = 2;
      end else begin
        n_cmp++;
        if ({a_valid, a_running, a_done} !== 3'b001 || a_pc !== mpc) begin
          n_bad++;
          $display("FAIL rnd_halted c=%0d got v/r/d=%b%b%b pc=%0d exp 001 pc=%0d",
                   c, a_valid, a_running, a_done, a_pc, mpc);
        end
        start = 1'b1;
        mpc = 3'd0;
        ph = 0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    instr_ready = 1'b0;
    jump = 1'b0;
    halt_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_halt_opcode();
    test_wrap_and_halt_req();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d compared", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
